// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  // Arbiter ownership state: no owner, or one port holding a lock.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter: counts contested A grants up to a limit.
// A clear request takes priority over an increment in the same cycle.
module arb_starve_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] lim,
  output logic [3:0] cnt,
  output logic       at_lim
);

  // Clear wins over increment; increment saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt < lim)) begin
      cnt <= cnt + 4'd1;
    end
  end

  // B must be forced through once the counter reaches the limit.
  assign at_lim = (cnt == lim);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-ported data memory.
// Handshake: a port's access is issued in the same cycle that req and gnt
// are both high (no separate ready); a read issued in cycle N is signalled
// by rvalid in cycle N+1, with rdata taken directly from the memory output.
// A granted port whose lock is high keeps exclusive ownership until it is
// granted again with lock low; the other port simply waits meanwhile.
module dmem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int DATA_W     = mem_pkg::DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // Port A: CPU load/store path
  input  logic                a_req,
  input  logic                a_lock,
  input  logic [ADDR_W-1:0]   a_adr,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  // Port B: secondary master
  input  logic                b_req,
  input  logic                b_lock,
  input  logic [ADDR_W-1:0]   b_adr,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  // Memory side
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  // Debug visibility of internal state
  output arb_state_t          dbg_state,
  output logic [3:0]          dbg_starve_cnt
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);
  localparam logic [DATA_W/8-1:0] WE_ZERO = '0;

  arb_state_t state;
  logic       rd_a;
  logic       rd_b;
  logic       at_lim;
  logic       a_win;
  logic       b_win;
  logic [3:0] starve_cnt;

  // Pick the winner from requests and ownership; mem_dout is not involved.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    case (state)
      OWN_A: a_win = a_req;
      OWN_B: b_win = b_req;
      default: begin
        if (a_req && b_req) begin
          b_win = at_lim;
          a_win = !at_lim;
        end else begin
          a_win = a_req;
          b_win = b_req;
        end
      end
    endcase
  end

  // Grants are suppressed while reset is asserted.
  assign a_gnt = a_win && rst_n;
  assign b_gnt = b_win && rst_n;

  // Route the winner to memory; with no grant, addresses follow port A.
  always_comb begin
    mem_adr = a_adr;
    mem_din = a_wdata;
    mem_we  = WE_ZERO;
    if (b_gnt) begin
      mem_adr = b_adr;
      mem_din = b_wdata;
      mem_we  = b_we;
    end else if (a_gnt) begin
      mem_we  = a_we;
    end
  end

  // Ownership FSM: only the granted port's lock is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (a_gnt) begin
      state <= a_lock ? OWN_A : IDLE;
    end else if (b_gnt) begin
      state <= b_lock ? OWN_B : IDLE;
    end else if ((state != OWN_A) && (state != OWN_B)) begin
      state <= IDLE;
    end
  end

  // Remember which port issued a read so its data is flagged next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= 1'b0;
      rd_b <= 1'b0;
    end else begin
      rd_a <= a_gnt && (a_we == WE_ZERO);
      rd_b <= b_gnt && (b_we == WE_ZERO);
    end
  end

  arb_starve_ctr u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (a_gnt && b_req),
    .clr    (b_gnt || !b_req),
    .lim    (LIM),
    .cnt    (starve_cnt),
    .at_lim (at_lim)
  );

  assign a_rvalid       = rd_a;
  assign b_rvalid       = rd_b;
  assign a_rdata        = mem_dout;
  assign b_rdata        = mem_dout;
  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with hand-computed expectations.
module tb_dmem_port_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_lock, b_req, b_lock;
  logic [11:0] a_adr, b_adr, mem_adr;
  logic [3:0]  a_we, b_we, mem_we;
  logic [31:0] a_wdata, b_wdata, mem_din, mem_dout, a_rdata, b_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  arb_state_t  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  int n_vec = 0;
  int n_err = 0;

  dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_lock(a_lock), .a_adr(a_adr), .a_we(a_we), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_adr(b_adr), .b_we(b_we), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_lock = 0; a_adr = '0; a_we = 0; a_wdata = '0;
    b_req = 0; b_lock = 0; b_adr = '0; b_we = 0; b_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_dout = '0;
    rst_n = 0;
    a_req = 1; a_we = 4'hF; a_adr = 12'h0AB; a_wdata = 32'h11223344;
    #1;
    n_vec++; if (a_gnt !== 1'b0) begin n_err++; $display("FAIL reset_a_gnt: got %b want 0", a_gnt); end
    n_vec++; if (mem_we !== 4'h0) begin n_err++; $display("FAIL reset_mem_we: got %h want 0", mem_we); end
    n_vec++; if (mem_adr !== 12'h0AB) begin n_err++; $display("FAIL reset_mem_adr: got %h want 0ab", mem_adr); end
    step();
    n_vec++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_vec++; if (dbg_starve_cnt !== 4'd0) begin n_err++; $display("FAIL reset_starve: got %0d want 0", dbg_starve_cnt); end
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_read();
    a_req = 1; a_adr = 12'h010; a_we = 0;
    #1;
    n_vec++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_err++; $display("FAIL rd_gnt: got a=%b b=%b want a=1 b=0", a_gnt, b_gnt); end
    n_vec++; if (mem_adr !== 12'h010 || mem_we !== 4'h0) begin n_err++; $display("FAIL rd_mem: got adr=%h we=%h want 010/0", mem_adr, mem_we); end
    step();
    a_req = 0; mem_dout = 32'hDEADBEEF;
    #1;
    n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b want 1", a_rvalid); end
    n_vec++; if (a_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", a_rdata); end
    n_vec++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_b_rvalid: got %b want 0", b_rvalid); end
    step();
    n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_drop: got %b want 0", a_rvalid); end
  endtask

  task automatic test_starvation();
    logic       exp_a   [10];
    logic [3:0] exp_cnt [10];
    exp_a   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    exp_cnt = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_adr = 12'h100; b_adr = 12'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec++; if (a_gnt !== exp_a[i] || b_gnt !== !exp_a[i]) begin n_err++; $display("FAIL starve_gnt[%0d]: got a=%b b=%b want a=%b", i, a_gnt, b_gnt, exp_a[i]); end
      n_vec++; if (dbg_starve_cnt !== exp_cnt[i]) begin n_err++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, dbg_starve_cnt, exp_cnt[i]); end
      step();
    end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL starve_state: got %0d want 0", dbg_state); end
    idle_inputs();
    step();
  endtask

  task automatic test_lock_b();
    b_req = 1; b_lock = 1; b_we = 4'b0011; b_wdata = 32'h0000ABCD; b_adr = 12'h3C0;
    a_adr = 12'h055;
    #1;
    n_vec++; if (b_gnt !== 1'b1) begin n_err++; $display("FAIL lockb_gnt: got %b want 1", b_gnt); end
    n_vec++; if (mem_we !== 4'b0011 || mem_din !== 32'h0000ABCD || mem_adr !== 12'h3C0) begin n_err++; $display("FAIL lockb_mem: got we=%h din=%h adr=%h want 3/0000abcd/3c0", mem_we, mem_din, mem_adr); end
    step();
    b_req = 0; b_lock = 0; b_we = 0; a_req = 1; a_we = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (a_gnt !== 1'b0 || mem_we !== 4'h0) begin n_err++; $display("FAIL lockb_a_blocked[%0d]: got gnt=%b we=%h want 0/0", i, a_gnt, mem_we); end
      n_vec++; if (dbg_state !== OWN_B || b_rvalid !== 1'b0) begin n_err++; $display("FAIL lockb_hold[%0d]: got state=%0d rvalid=%b want 2/0", i, dbg_state, b_rvalid); end
      step();
    end
    b_req = 1; b_lock = 0; b_we = 0; b_adr = 12'h3C4;
    #1;
    n_vec++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_adr !== 12'h3C4) begin n_err++; $display("FAIL lockb_release: got b=%b a=%b adr=%h want 1/0/3c4", b_gnt, a_gnt, mem_adr); end
    step();
    b_req = 0; a_req = 0; mem_dout = 32'h12345678;
    #1;
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL lockb_state: got %0d want 0", dbg_state); end
    n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678) begin n_err++; $display("FAIL lockb_read: got %b/%h want 1/12345678", b_rvalid, b_rdata); end
    step();
  endtask

  task automatic test_reset_mid_lock();
    a_req = 1; a_lock = 1; a_we = 0; a_adr = 12'h020;
    #1;
    n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_gnt: got %b want 1", a_gnt); end
    step();
    a_adr = 12'h021; b_req = 1; b_adr = 12'h0F0;
    #1;
    n_vec++; if (dbg_state !== OWN_A || a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_err++; $display("FAIL midrst_own: got st=%0d a=%b b=%b want 1/1/0", dbg_state, a_gnt, b_gnt); end
    n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL midrst_rv_pre: got %b want 1", a_rvalid); end
    rst_n = 0;
    #1;
    n_vec++; if (a_rvalid !== 1'b0 || dbg_state !== IDLE || a_gnt !== 1'b0) begin n_err++; $display("FAIL midrst_clear: got rv=%b st=%0d gnt=%b want 0/0/0", a_rvalid, dbg_state, a_gnt); end
    step();
    n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_inflight: got %b want 0", a_rvalid); end
    rst_n = 1; a_req = 0; a_lock = 0;
    #1;
    n_vec++; if (b_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_b_after: got %b want 1", b_gnt); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    a_req = 1; a_we = 4'b1111; a_wdata = 32'hCAFEF00D; a_adr = 12'h040;
    #1;
    n_vec++; if (a_gnt !== 1'b1 || mem_we !== 4'b1111 || mem_din !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_write: got gnt=%b we=%h din=%h want 1/f/cafef00d", a_gnt, mem_we, mem_din); end
    step();
    a_we = 0; a_adr = 12'h041;
    #1;
    n_vec++; if (a_gnt !== 1'b1 || mem_we !== 4'b0000) begin n_err++; $display("FAIL b2b_read: got gnt=%b we=%h want 1/0", a_gnt, mem_we); end
    n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_rv_c2: got %b want 0", a_rvalid); end
    step();
    a_req = 0;
    #1;
    n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_rv_c3: got %b want 1", a_rvalid); end
    step();
  endtask

  task automatic test_idle();
    idle_inputs();
    a_adr = 12'h123; a_wdata = 32'h0BADC0DE; b_adr = 12'h456; b_we = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (mem_we !== 4'h0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_err++; $display("FAIL idle_gnt[%0d]: got we=%h a=%b b=%b want 0/0/0", i, mem_we, a_gnt, b_gnt); end
      n_vec++; if (mem_adr !== 12'h123 || mem_din !== 32'h0BADC0DE) begin n_err++; $display("FAIL idle_mem[%0d]: got adr=%h din=%h want 123/0badc0de", i, mem_adr, mem_din); end
      n_vec++; if (dbg_starve_cnt !== 4'd0) begin n_err++; $display("FAIL idle_starve[%0d]: got %0d want 0", i, dbg_starve_cnt); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_starvation();
    test_lock_b();
    test_reset_mid_lock();
    test_back_to_back();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-ported data memory between two requesters: port A, the CPU load/store path (word address and byte write enables already aligned), and port B, a secondary master such as the UART loader or a debug/DMA engine. The grant is combinational in the request cycle, so an uncontested CPU access costs no stall. Reads return one cycle later with a per-port valid. A starvation counter and a lock mechanism give fair, atomic sharing. The block sits between the load/store address logic and the dmem/imem block RAM write/read ports.

## Interface
- `ADDR_W`, 12: word address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8`.
- `STARVE_LIM`, 4: consecutive contested A grants before B is forced through; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  A requests an access this cycle.
- `a_lock`  in  1  A keeps ownership after this access; sampled only when `a_gnt` is high.
- `a_adr`  in  `ADDR_W`  A word address.
- `a_we`  in  4  A byte write enables; 0 means read.
- `a_wdata`  in  `DATA_W`  A write data, already lane-aligned.
- `a_gnt`  out  1  A access is issued to memory this cycle.
- `a_rvalid`  out  1  `a_rdata` holds the result of A's read granted last cycle.
- `a_rdata`  out  `DATA_W`  always equal to `mem_dout`.
- `b_req`, `b_lock`, `b_adr`, `b_we`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the A ports, for B.
- `mem_adr`  out  `ADDR_W`  memory address.
- `mem_we`  out  4  memory byte write enables.
- `mem_din`  out  `DATA_W`  memory write data.
- `mem_dout`  in  `DATA_W`  memory read data; synchronous, 1-cycle latency.

## Operation
- FSM states:
  - `IDLE`: no owner.
  - `OWN_A`: A holds a lock.
  - `OWN_B`: B holds a lock.
- Grant in `IDLE`:
  - Only one request present: that port wins.
  - Both present: A wins unless `starve_cnt == STARVE_LIM`, in which case B wins.
- Grant in `OWN_A`:
  - A is granted whenever `a_req` is high.
  - `b_req` is never granted; B simply waits, with no error.
- Grant in `OWN_B`: symmetric to `OWN_A`.
- Lock transitions:
  - Granted port with its lock high: go to (or stay in) `OWN_x`.
  - Granted port with its lock low: return to `IDLE`.
  - Owner with `req` low: no grant, and the state is held (the lock persists across idle cycles).
- Memory drive:
  - Winner's `adr`/`we`/`wdata` go to `mem_*`.
  - With no grant, `mem_we` is 0 and `mem_adr`/`mem_din` hold the A inputs.
- `starve_cnt` (4 bits):
  - +1 on each A grant while `b_req` is high, saturating at `STARVE_LIM`.
  - Cleared on any B grant, and on any cycle where `b_req` is low.
- Read tracking:
  - Registered `rd_a` is set when `a_gnt & (a_we == 0)`, cleared otherwise; `a_rvalid = rd_a`.
  - `rd_b` / `b_rvalid` follow the same rule for B.
- Writes: complete in the grant cycle and never raise `rvalid`.

## Timing
- Reset (async assert, sync-safe deassert): state `IDLE`, `starve_cnt = 0`, `a_rvalid = b_rvalid = 0`.
- During reset the combinational outputs still follow the inputs, except that `a_gnt`, `b_gnt` and `mem_we` are forced to 0 while `rst_n` is low.
- Grant latency: 0 cycles, combinational from `req`/state. Read data latency: 1 cycle after the grant.
- Back-to-back grants to the same port are allowed every cycle. A read followed by a write on the next cycle overlaps the `rvalid` of the read.
- Reset mid-operation:
  - A pending `rvalid` is dropped.
  - Any lock is released.
  - A read in flight yields no `rvalid`.
- Both requesters locking in the same cycle: only the winner's lock is sampled.
- No combinational path from `mem_dout` to any grant.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - State enum `arb_state_t {IDLE, OWN_A, OWN_B}`.
  - `WE_NONE = 4'b0000`.
- One sub-module, `arb_starve_ctr`: the saturating counter, with inputs `inc`, `clr` and the limit, and output `at_lim`.
- Grant logic, FSM and read tracking stay in the top level.

## Test plan
- Only `a_req`, `a_adr = 12'h010`, `a_we = 0`, `mem_dout = 32'hDEADBEEF` the next cycle -> `a_gnt = 1` the same cycle, then `a_rvalid = 1` and `a_rdata = 32'hDEADBEEF`; `b_rvalid` stays 0.
- `a_req` and `b_req` held high with `STARVE_LIM = 4`, both reading -> grant sequence A,A,A,A,B, repeating; `starve_cnt` is back to 0 after each B grant.
- B write with `b_we = 4'b0011`, `b_wdata = 32'h0000ABCD`, `b_lock = 1`, then `a_req` for 3 cycles while `b_req` is low -> `a_gnt = 0` throughout. B then reads with `b_lock = 0` -> `b_gnt = 1`, and the state returns to `IDLE`.
- A in `OWN_A`, `rst_n` pulsed low for 1 cycle mid-lock with a read in flight -> `a_rvalid = 0` and the state is `IDLE`. After release, `b_req` alone gets `b_gnt = 1`.
- A write `a_we = 4'b1111` granted, then an A read on the next cycle -> `mem_we = 4'b1111` then `4'b0000`; `a_rvalid` is low in cycle 2 and high in cycle 3 only.
- No requests -> `mem_we = 0`, both grants 0, and `starve_cnt` is held at 0.
